adder_measure_ctrl: RTL and testbench
=====================================

ADDER_MEASURE_CTRL -- requirements
Module: adder_measure_ctrl

Interface
REQ-001 Parameters SHALL be: COUNT_W, default 32, ring-edge counter width; SYNC_STAGES, default 2, chain_out synchronizer depth (min 2).
REQ-002 wb_clk_i  in  1  sole clock.
REQ-003 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  begin a measurement; sampled only in IDLE.
REQ-005 abort  in  1  return to IDLE from any state; no done pulse.
REQ-006 a_in, b_in  in  32 each  adder operands to apply.
REQ-007 ring_sel  in  32  one-hot bit that closes the ring through the adder.
REQ-008 settle_cycles  in  4  operand settle time before the ring is enabled.
REQ-009 gate_cycles  in  16  measurement window length; 0 treated as 1.
REQ-010 chain_out  in  1  asynchronous ring output from the instrumented adder.
REQ-011 adder_a, adder_b  out  32 each  registered operands to the adder.
REQ-012 ring_mask  out  32  registered ring bit mask; 0 when ring disabled.
REQ-013 ring_en  out  1  ring oscillator enable.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when count/ovf become valid.
REQ-016 count  out  COUNT_W  rising edges of chain_out counted in the window.
REQ-017 ovf  out  1  counter exceeded 2^COUNT_W-1 in the last window.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, SETTLE, RUN, DRAIN, DONE.
REQ-019 IDLE->LOAD on start; LOAD captures a_in, b_in, ring_sel, settle_cycles, gate_cycles into adder_a/adder_b/internal registers, clears edge counter and ovf.
REQ-020 LOAD->SETTLE after 1 cycle; SETTLE lasts settle_cycles+1 cycles, ring_en=0, ring_mask=0.
REQ-021 RUN: ring_en=1, ring_mask=captured ring_sel, lasts exactly max(gate_cycles,1) cycles; counter increments once per synchronized rising edge of chain_out.
REQ-022 DRAIN: ring_en=0, ring_mask=0, lasts SYNC_STAGES+1 cycles so in-flight edges are still counted.
REQ-023 DONE: count and ovf updated from the counter, done=1 for that single cycle, then IDLE.
REQ-024 count/ovf SHALL hold their value from the last DONE until the next DONE; inputs changing during busy SHALL have no effect.
REQ-025 Edge detect SHALL use SYNC_STAGES flops plus one history flop; one increment per detected rising edge, maximum one per cycle.
REQ-026 abort SHALL take priority over every transition, force ring_en=0, ring_mask=0 next cycle, leave count/ovf unchanged, and enter IDLE; start and abort together in IDLE -> stay IDLE.
REQ-027 start asserted while busy SHALL be ignored (no queuing).

Reset
REQ-028 On wb_rst_i: state IDLE, adder_a=adder_b=0, ring_mask=0, ring_en=0, busy=0, done=0, count=0, ovf=0, synchronizer flops 0.
REQ-029 Reset mid-measurement SHALL drop ring_en immediately (asynchronously) and discard the partial count.

Configuration
REQ-030 With ADDER_MEASURE_SATURATE_EN defined, the counter SHALL stop at 2^COUNT_W-1 and set ovf; without it, the counter SHALL wrap to 0 and set ovf (sticky for the window) on the wrap.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, default COUNT_W/SYNC_STAGES constants and DRAIN length derivation.
REQ-032 Sub-module edge_sync_counter (synchronizer + edge detect + counter, saturate/wrap logic) SHALL be instantiated once.

Verification
REQ-033 start, a_in=0x0000FFFF, b_in=1, ring_sel=0x02000000, settle=3, gate=10, chain_out toggling every 2 clocks -> ring_en high exactly 10 cycles, done once, count=5 (±1 at window edges).
REQ-034 gate_cycles=0, chain_out static -> RUN lasts 1 cycle, count=0, ovf=0, done pulse.
REQ-035 COUNT_W=4, chain_out toggling each cycle, gate=40 -> saturate build: count=15, ovf=1; wrap build: count=(edges mod 16), ovf=1.
REQ-036 abort in cycle 3 of RUN -> ring_en/ring_mask 0 next cycle, no done, count keeps previous value, busy=0.
REQ-037 wb_rst_i asserted asynchronously during RUN -> ring_en low before next clock edge, all outputs at reset values; start pulses during busy -> no second measurement.

Source files
------------

// File: rtl/adder_measure_ctrl_pkg.sv
// adder_measure_ctrl_pkg: FSM states, default widths and drain length shared by adder_measure_ctrl
package adder_measure_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DRAIN, DONE} state_t;
  localparam int COUNT_W_DEF = 32;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic int drain_len(input int sync_stages);
    return sync_stages + 1;
  endfunction
endpackage

// File: rtl/adder_measure_ctrl_edge_sync_counter.sv
// adder_measure_ctrl_edge_sync_counter: chain_out synchronizer, rising-edge detect and window counter; ADDER_MEASURE_SATURATE_EN saturates instead of wrapping
module adder_measure_ctrl_edge_sync_counter
  import adder_measure_ctrl_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               clear,
  input  logic               en,
  input  logic               chain_out,
  output logic [COUNT_W-1:0] cnt,
  output logic               ovf
);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  logic rise;
  assign rise = sync[SYNC_STAGES-1] & ~hist;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], chain_out};
      hist <= sync[SYNC_STAGES-1];
    end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en && rise) begin
`ifdef ADDER_MEASURE_SATURATE_EN
      cnt <= &cnt ? cnt : cnt + COUNT_W'(1);
      ovf <= ovf | &cnt;
`else
      cnt <= cnt + COUNT_W'(1);
      ovf <= ovf | &cnt;
`endif
    end
endmodule

// File: rtl/adder_measure_ctrl.sv
// adder_measure_ctrl: adder ring-oscillator measurement sequencer (optional ADDER_MEASURE_SATURATE_EN saturating counter)
module adder_measure_ctrl
  import adder_measure_ctrl_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        a_in,
  input  logic [31:0]        b_in,
  input  logic [31:0]        ring_sel,
  input  logic [3:0]         settle_cycles,
  input  logic [15:0]        gate_cycles,
  input  logic               chain_out,
  output logic [31:0]        adder_a,
  output logic [31:0]        adder_b,
  output logic [31:0]        ring_mask,
  output logic               ring_en,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               ovf
);
  localparam logic [15:0] DRAIN_LAST = 16'(drain_len(SYNC_STAGES) - 1);
  state_t state;
  logic [31:0] sel_r;
  logic [15:0] gate_r;
  logic [15:0] timer;
  logic [COUNT_W-1:0] cnt;
  logic cnt_ovf;
  logic cnt_en;
  assign cnt_en = state == RUN || (state == DRAIN && timer != '0);
  adder_measure_ctrl_edge_sync_counter #(
    .COUNT_W(COUNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) edge_sync_counter (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .clear(state == LOAD),
    .en(cnt_en),
    .chain_out(chain_out),
    .cnt(cnt),
    .ovf(cnt_ovf)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      adder_a <= '0;
      adder_b <= '0;
      ring_mask <= '0;
      ring_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      count <= '0;
      ovf <= 1'b0;
      sel_r <= '0;
      gate_r <= '0;
      timer <= '0;
    end else if (abort) begin
      state <= IDLE;
      ring_mask <= '0;
      ring_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy <= 1'b1;
          adder_a <= a_in;
          adder_b <= b_in;
          sel_r <= ring_sel;
          gate_r <= gate_cycles;
          timer <= 16'(settle_cycles);
        end
        LOAD: state <= SETTLE;
        SETTLE: if (timer == '0) begin
          state <= RUN;
          ring_en <= 1'b1;
          ring_mask <= sel_r;
          timer <= gate_r == '0 ? '0 : gate_r - 16'd1;
        end else timer <= timer - 16'd1;
        RUN: if (timer == '0) begin
          state <= DRAIN;
          ring_en <= 1'b0;
          ring_mask <= '0;
          timer <= DRAIN_LAST;
        end else timer <= timer - 16'd1;
        DRAIN: if (timer == '0) begin
          state <= DONE;
          count <= cnt;
          ovf <= cnt_ovf;
          done <= 1'b1;
        end else timer <= timer - 16'd1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_adder_measure_ctrl.sv
// tb_adder_measure_ctrl: table-driven and randomized checks of adder_measure_ctrl against an edge-counting model
module tb_adder_measure_ctrl;
  localparam int CW = 4;
`ifdef ADDER_MEASURE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sel;
    logic [3:0]  st;
    logic [15:0] g;
    int          per;
    int          exp_cnt;
    bit          exp_ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic chain_out = 1'b0;
  logic [31:0] a_in = '0, b_in = '0, ring_sel = '0;
  logic [3:0] settle_cycles = '0;
  logic [15:0] gate_cycles = '0;
  logic [31:0] adder_a, adder_b, ring_mask;
  logic ring_en, busy, done, ovf;
  logic [CW-1:0] count;
  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[8];
  adder_measure_ctrl #(.COUNT_W(CW), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .start(start),
    .abort(abort),
    .a_in(a_in),
    .b_in(b_in),
    .ring_sel(ring_sel),
    .settle_cycles(settle_cycles),
    .gate_cycles(gate_cycles),
    .chain_out(chain_out),
    .adder_a(adder_a),
    .adder_b(adder_b),
    .ring_mask(ring_mask),
    .ring_en(ring_en),
    .busy(busy),
    .done(done),
    .count(count),
    .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic scramble();
    a_in = $urandom;
    b_in = $urandom;
    ring_sel = $urandom;
    settle_cycles = 4'($urandom);
    gate_cycles = 16'($urandom);
  endtask
  task automatic measure(input vec_t v, input bit noise, output int rises);
    int ring, pre, dones;
    bit mask_bad;
    ring = 0;
    pre = 0;
    dones = 0;
    rises = 0;
    mask_bad = 0;
    chain_out = 1'b0;
    a_in = v.a;
    b_in = v.b;
    ring_sel = v.sel;
    settle_cycles = v.st;
    gate_cycles = v.g;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    chk("busy_after_start", 64'(busy), 64'(1));
    for (int c = 0; c < 400 && busy === 1'b1; c++) begin
      if (done) dones++;
      if (ring_en) begin
        if (ring_mask !== v.sel) mask_bad = 1;
        if (v.per != 0 && ring % v.per == 0) begin
          chain_out = ~chain_out;
          if (chain_out) rises++;
        end
        ring++;
      end else begin
        if (ring_mask !== '0) mask_bad = 1;
        if (ring == 0) pre++;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        scramble();
      end
      tick();
    end
    start = 1'b0;
    chk("measure_finished", 64'(busy), 64'(0));
    chk("pre_run_cycles", 64'(pre), 64'(v.st + 2));
    chk("ring_en_cycles", 64'(ring), 64'(v.g == 0 ? 1 : v.g));
    chk("done_pulses", 64'(dones), 64'(1));
    chk("ring_mask_ok", 64'(mask_bad), 64'(0));
    chk("adder_a", 64'(adder_a), 64'(v.a));
    chk("adder_b", 64'(adder_b), 64'(v.b));
    for (int c = 0; c < 3; c++) begin
      if (busy !== 1'b0 || done !== 1'b0) mask_bad = 1;
      tick();
    end
    chk("no_second_run", 64'(mask_bad), 64'(0));
  endtask
  function automatic int model_cnt(input int r);
    return SAT ? (r > 15 ? 15 : r) : r % 16;
  endfunction
  initial begin
    int r;
    int seen;
    vec_t v;
    logic [CW-1:0] prev_cnt;
    logic prev_ovf;
    bit bad;
    tbl[0] = '{32'h0000FFFF, 32'h1, 32'h02000000, 4'd3, 16'd10, 1, 5, 1'b0};
    tbl[1] = '{32'h0, 32'h0, 32'h1, 4'd0, 16'd0, 0, 0, 1'b0};
    tbl[2] = '{32'hAAAA5555, 32'h12345678, 32'h80000000, 4'd15, 16'd40, 1, SAT ? 15 : 4, 1'b1};
    tbl[3] = '{32'hFFFFFFFF, 32'h1, 32'h4, 4'd2, 16'd15, 1, 8, 1'b0};
    tbl[4] = '{32'h1234, 32'h4321, 32'h100, 4'd1, 16'd30, 1, 15, 1'b0};
    tbl[5] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h8, 4'd5, 16'd32, 1, SAT ? 15 : 0, 1'b1};
    tbl[6] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h10000, 4'd7, 16'd7, 3, 2, 1'b0};
    tbl[7] = '{32'h5, 32'h6, 32'h40, 4'd0, 16'd1, 1, 1, 1'b0};
    #12;
    chk("rst_adder_a", 64'(adder_a), 64'(0));
    chk("rst_adder_b", 64'(adder_b), 64'(0));
    chk("rst_ring_mask", 64'(ring_mask), 64'(0));
    chk("rst_ring_en", 64'(ring_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    foreach (tbl[i]) begin
      measure(tbl[i], 1'b0, r);
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].exp_ovf));
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 64'(busy), 64'(0));
    prev_cnt = count;
    prev_ovf = ovf;
    a_in = 32'h11;
    b_in = 32'h22;
    ring_sel = 32'h800;
    settle_cycles = 4'd2;
    gate_cycles = 16'd20;
    chain_out = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 60 && seen < 3; c++) begin
      if (ring_en) seen++;
      if (seen < 3) tick();
    end
    chk("abort_run_reached", 64'(seen), 64'(3));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ring_en", 64'(ring_en), 64'(0));
    chk("abort_ring_mask", 64'(ring_mask), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_count_kept", 64'(count), 64'(prev_cnt));
    chk("abort_ovf_kept", 64'(ovf), 64'(prev_ovf));
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
      tick();
    end
    chk("abort_no_done", 64'(bad), 64'(0));
    a_in = 32'h33;
    b_in = 32'h44;
    ring_sel = 32'h1000;
    settle_cycles = 4'd1;
    gate_cycles = 16'd25;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (ring_en) seen = 1;
      else tick();
    end
    chk("rst_run_reached", 64'(seen), 64'(1));
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ring_en", 64'(ring_en), 64'(0));
    chk("async_rst_mask", 64'(ring_mask), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_count", 64'(count), 64'(0));
    chk("async_rst_adder_a", 64'(adder_a), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    for (int n = 0; n < 12; n++) begin
      v.a = $urandom;
      v.b = $urandom;
      v.sel = 32'h1 << $urandom_range(0, 31);
      v.st = 4'($urandom);
      v.g = 16'($urandom_range(0, 40));
      v.per = $urandom_range(0, 4);
      measure(v, 1'b1, r);
      chk($sformatf("rnd%0d_count", n), 64'(count), 64'(model_cnt(r)));
      chk($sformatf("rnd%0d_ovf", n), 64'(ovf), 64'(r > 15));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
